// File: rtl/vga_fb_ctrl.sv
// ============================================================================
// Module  : vga_fb_ctrl
// Purpose : Shares a 1RW framebuffer RAM between a sequential display-read
//           stream (into a prefetch FIFO) and a host write port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_fb_ctrl #(
  parameter int AW         = 10,
  parameter int DW         = 12,
  parameter int FRAME_SIZE = 1 << AW,
  parameter int DEPTH      = 4,
  parameter int LOW_WM     = 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  input  logic          host_valid,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_data,
  output logic          host_ready,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [DW-1:0] pix_data,
  output logic          pix_sof,
  input  logic          frame_restart
);

  localparam int            c_PW     = $clog2(DEPTH);
  localparam logic [c_PW:0] c_DEPTH  = (c_PW+1)'(DEPTH);
  localparam logic [c_PW:0] c_LOW_WM = (c_PW+1)'(LOW_WM);
  localparam logic [AW-1:0] c_LAST   = AW'(FRAME_SIZE - 1);

  logic [AW-1:0]   r_rd_addr;
  logic            r_inflight;
  logic            r_inflight_sof;
  logic [DW:0]     r_mem [DEPTH];
  logic [c_PW-1:0] r_wp;
  logic [c_PW-1:0] r_rp;
  logic [c_PW:0]   r_count;

  logic [c_PW:0]   w_occ;
  logic            w_read_go;
  logic            w_host_wr;
  logic            w_push;
  logic            w_pop;
  logic            w_pix_valid;

  // In-flight read counts toward occupancy so FIFO space is reserved at issue.
  assign w_occ       = r_count + (c_PW+1)'(r_inflight);
  assign w_read_go   = !rst && !frame_restart && (w_occ < c_DEPTH) &&
                       !(host_valid && (w_occ >= c_LOW_WM));
  assign host_ready  = !rst && !frame_restart && !w_read_go;
  assign w_host_wr   = host_valid && host_ready;

  assign ram_we      = w_host_wr;
  assign ram_addr    = w_host_wr ? host_addr : r_rd_addr;
  assign ram_din     = host_data;

  assign w_pix_valid = (r_count != '0);
  assign w_push      = r_inflight && !rst && !frame_restart;
  assign w_pop       = w_pix_valid && pix_ready && !rst && !frame_restart;

  assign pix_valid   = w_pix_valid;
  assign pix_data    = r_mem[r_rp][DW-1:0];
  assign pix_sof     = w_pix_valid && r_mem[r_rp][DW];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= {r_inflight_sof, ram_dout};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || frame_restart) begin
      r_rd_addr      <= '0;
      r_inflight     <= 1'b0;
      r_inflight_sof <= 1'b0;
      r_wp           <= '0;
      r_rp           <= '0;
      r_count        <= '0;
    end else begin
      r_inflight <= w_read_go;
      if (w_read_go) begin
        r_rd_addr      <= (r_rd_addr == c_LAST) ? '0 : r_rd_addr + AW'(1);
        r_inflight_sof <= (r_rd_addr == '0);
      end
      if (w_push) begin
        r_wp <= r_wp + c_PW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + c_PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PW+1)'(1);
        2'b01:   r_count <= r_count - (c_PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_ctrl.sv
// ============================================================================
// Module  : tb_vga_fb_ctrl
// Purpose : Scoreboard bench for vga_fb_ctrl with a 1-cycle RAM model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_fb_ctrl;

  localparam int c_AW = 10;
  localparam int c_DW = 12;
  localparam int c_FS = 640;

  logic            clk = 1'b0;
  logic            rst;
  logic            ram_we;
  logic [c_AW-1:0] ram_addr;
  logic [c_DW-1:0] ram_din;
  logic [c_DW-1:0] ram_dout;
  logic            host_valid;
  logic [c_AW-1:0] host_addr;
  logic [c_DW-1:0] host_data;
  logic            host_ready;
  logic            pix_valid;
  logic            pix_ready;
  logic [c_DW-1:0] pix_data;
  logic            pix_sof;
  logic            frame_restart;

  vga_fb_ctrl #(
    .AW(c_AW), .DW(c_DW), .FRAME_SIZE(c_FS), .DEPTH(4), .LOW_WM(2)
  ) u_dut (
    .clk(clk), .rst(rst),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data),
    .host_ready(host_ready),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sof(pix_sof), .frame_restart(frame_restart)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          pops = 0;
  int          head_addr = 0;
  logic        host_acc = 1'b0;
  logic        preload = 1'b1;
  int          exp_q[$];
  logic [11:0] ram     [1024];
  logic [11:0] ref_mem [1024];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 12'(i);
    end else begin
      if (ram_we) ram[ram_addr] <= ram_din;
      ram_dout <= ram[ram_addr];
    end
  end

  // Monitor: tracks accepted host writes and scores every pixel transfer.
  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 12'(i);
    end
    host_acc = host_valid && host_ready;
    if (!rst && host_valid && host_ready) ref_mem[host_addr] = host_data;
    if (!rst && pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_pixel", 1, 0);
      end else begin
        int a;
        a = exp_q.pop_front();
        chk("sb_data", int'(pix_data), int'(ref_mem[a]));
        chk("sb_sof", int'(pix_sof), int'(a == 0));
        head_addr = (a + 1) % c_FS;
      end
      pops++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic push_range(input int a0, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back((a0 + i) % c_FS);
  endtask

  task automatic wait_pops(input int target);
    int budget;
    int n;
    budget = (target - pops) * 4 + 50;
    n = 0;
    pix_ready = 1'b1;
    while (pops < target && n < budget) begin
      step();
      n++;
    end
    pix_ready = 1'b0;
    chk("pop_count", pops, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pix_ready = 1'b1; frame_restart = 1'b0;
    host_valid = 1'b1; host_addr = 10'd5; host_data = 12'h123;
    repeat (2) step();
    preload = 1'b0;

    // Reset holds off both the host and the display stream.
    repeat (3) begin
      mid();
      chk("rst_host_ready", int'(host_ready), 0);
      chk("rst_ram_we", int'(ram_we), 0);
      chk("rst_pix_valid", int'(pix_valid), 0);
      chk("rst_pix_sof", int'(pix_sof), 0);
    end
    step();
    rst = 1'b0; host_valid = 1'b0;
    push_range(0, 20);
    mid(); chk("rel_c1_valid", int'(pix_valid), 0);
    mid(); chk("rel_c2_valid", int'(pix_valid), 0);
    mid(); chk("rel_c3_valid", int'(pix_valid), 1);
    chk("rel_c3_sof", int'(pix_sof), 1);
    repeat (19) mid();
    chk("throughput_pops", pops, 20);
    step();
    pix_ready = 1'b0;

    // Backpressure: FIFO fills to DEPTH and reads stop.
    push_range(20, 20);
    repeat (8) step();
    mid();
    chk("bp_valid", int'(pix_valid), 1);
    chk("bp_full_host_ready", int'(host_ready), 1);
    chk("bp_no_pop", pops, 20);
    step();
    wait_pops(40);

    // Arbitration around the low watermark.
    repeat (6) step();
    push_range(40, 3);
    host_valid = 1'b1; host_addr = 10'h3FF; host_data = 12'hABC;
    wait_pops(42);
    mid();
    chk("arb_ready_occ2", int'(host_ready), 1);
    chk("arb_we_occ2", int'(ram_we), 1);
    chk("arb_addr_occ2", int'(ram_addr), 'h3FF);
    chk("arb_din_occ2", int'(ram_din), 'hABC);
    step();
    wait_pops(43);
    mid();
    chk("arb_ready_occ1", int'(host_ready), 0);
    chk("arb_we_occ1", int'(ram_we), 0);
    chk("arb_read_addr_occ1", int'(ram_addr), 44);
    step(); mid();
    chk("arb_ready_after_read", int'(host_ready), 1);
    step();
    host_valid = 1'b0;

    // Wrap from 639 back to 0.
    push_range(43, c_FS - 43 + 10);
    wait_pops(650);

    // frame_restart with full FIFO and a read in flight.
    repeat (6) step();
    push_range(10, 1);
    wait_pops(651);
    step();
    frame_restart = 1'b1;
    host_valid = 1'b1; host_addr = 10'd5; host_data = 12'h777;
    mid();
    chk("rs_we", int'(ram_we), 0);
    chk("rs_host_ready", int'(host_ready), 0);
    step();
    frame_restart = 1'b0; host_valid = 1'b0;
    exp_q.delete();
    push_range(0, 16);
    mid();
    chk("rs_flushed", int'(pix_valid), 0);
    chk("rs_read_addr0", int'(ram_addr), 0);
    step(); mid();
    chk("rs_c2_valid", int'(pix_valid), 0);
    step(); mid();
    chk("rs_c3_valid", int'(pix_valid), 1);
    chk("rs_c3_sof", int'(pix_sof), 1);
    step();
    wait_pops(667);

    // Random traffic: host writes land well ahead of the display head.
    push_range(16, c_FS - 16);
    push_range(0, c_FS);
    push_range(0, c_FS);
    begin
      int target;
      int n;
      target = 667 + 3 * c_FS - 16;
      n = 0;
      while (pops < target && n < 20000) begin
        pix_ready = ($urandom_range(3) != 0);
        if (host_acc) host_valid = 1'b0;
        if (!host_valid && $urandom_range(1) == 1) begin
          host_valid = 1'b1;
          host_addr  = 10'((head_addr + 200) % c_FS);
          host_data  = 12'($urandom);
        end
        step();
        n++;
      end
      pix_ready = 1'b0;
      host_valid = 1'b0;
      chk("rnd_pop_count", pops, target);
    end
    repeat (4) step();
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
